// File: rtl/vga_char_pkg.sv
// Shared constants and types for the character video writer.
// Geometry, request bundle and writer FSM states.
package vga_char_pkg;

  localparam int COLS       = 40;
  localparam int ROWS       = 30;
  localparam int CELLS      = COLS * ROWS;
  localparam int ADDR_W     = 11;
  localparam int FIFO_DEPTH = 4;

  localparam logic [15:0] CLEAR_CHAR = 16'h0000;

  typedef struct packed {
    logic [15:0] pos;
    logic [15:0] chr;
  } vga_req_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } wr_state_t;

endpackage

// File: rtl/vga_char_writer_if.sv
// Video RAM write port between the writer and the VGA side.
// The VGA side grants a write slot with vram_ready.
interface vga_char_writer_if;
  import vga_char_pkg::*;

  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [15:0]       vram_data;
  logic              vram_ready;

  modport master (
    output vram_we,
    output vram_addr,
    output vram_data,
    input  vram_ready
  );

  modport slave (
    input  vram_we,
    input  vram_addr,
    input  vram_data,
    output vram_ready
  );

endinterface

// File: rtl/vga_char_writer_sync_fifo.sv
// Small synchronous FIFO for queued write requests.
// A push into a full FIFO succeeds only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // storage: data only, pointers qualify validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push & ~do_pop)
        count <= count + (AW+1)'(1);
      else if (do_pop & ~do_push)
        count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/vga_char_writer.sv
// Queues core character writes and drains them into video RAM.
// Also runs a full-screen clear without stalling the core.
module vga_char_writer
  import vga_char_pkg::*;
(
  input  logic               wire_clock,
  input  logic               wire_reset,
  input  logic               videoflag,
  input  logic [15:0]        bus_vga_pos,
  input  logic [15:0]        bus_vga_char,
  input  logic               clr_req,
  vga_char_writer_if.master  vram,
  output logic               busy,
  output logic               overflow,
  output logic               range_err,
  output logic [7:0]         drop_cnt
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);
  localparam logic [15:0] CELLS_W = 16'(CELLS);

  wr_state_t         state;
  wr_state_t         state_n;
  logic              flag_q;
  logic              clr_q;
  logic              req_edge;
  logic              clr_edge;
  logic [ADDR_W-1:0] clr_cnt;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_n;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              drop;
  logic              push_ok;
  logic              in_range;
  logic              bad;
  logic [8:0]        drop_sum;
  vga_req_t          req;
  vga_req_t          head;

  assign req_edge = videoflag & ~flag_q;
  assign clr_edge = clr_req & ~clr_q;
  assign req      = '{pos: bus_vga_pos, chr: bus_vga_char};
  assign drop     = req_edge & fifo_full & ~pop;
  assign push_ok  = req_edge & ~drop;
  assign in_range = head.pos < CELLS_W;
  assign bad      = pop & ~in_range;
  assign drop_sum = {1'b0, drop_cnt} + 9'(drop) + 9'(bad);

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wire_clock),
    .rst_n (wire_reset),
    .push  (push_ok),
    .pop   (pop),
    .din   (req),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // next state and pop decision; a clear request beats a pop
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_edge)
          state_n = CLEAR;
        else if (!fifo_empty && vram.vram_ready)
          pop = 1'b1;
      end
      CLEAR: begin
        if (vram.vram_ready && clr_cnt == LAST)
          state_n = IDLE;
      end
    endcase
  end

  // queue occupancy after this cycle, feeds the registered busy
  always_comb begin
    occ_n = occ;
    if (push_ok & ~pop)
      occ_n = occ + OCC_W'(1);
    else if (pop & ~push_ok)
      occ_n = occ - OCC_W'(1);
  end

  // state, edge detectors, clear counter and status
  always_ff @(posedge wire_clock or negedge wire_reset) begin
    if (!wire_reset) begin
      state     <= IDLE;
      flag_q    <= 1'b0;
      clr_q     <= 1'b0;
      clr_cnt   <= '0;
      occ       <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      range_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state  <= state_n;
      flag_q <= videoflag;
      clr_q  <= clr_req;
      occ    <= occ_n;
      busy   <= (state_n == CLEAR) | (occ_n != '0);
      if (state == IDLE)
        clr_cnt <= '0;
      else if (vram.vram_ready)
        clr_cnt <= (clr_cnt == LAST) ? '0 : clr_cnt + ADDR_W'(1);
      if (drop) overflow  <= 1'b1;
      if (bad)  range_err <= 1'b1;
      drop_cnt <= drop_sum[8] ? 8'hff : drop_sum[7:0];
    end
  end

  // video RAM write port; address and data hold when idle
  always_ff @(posedge wire_clock or negedge wire_reset) begin
    if (!wire_reset) begin
      vram.vram_we   <= 1'b0;
      vram.vram_addr <= '0;
      vram.vram_data <= '0;
    end else begin
      vram.vram_we <= 1'b0;
      if (state == CLEAR && vram.vram_ready) begin
        vram.vram_we   <= 1'b1;
        vram.vram_addr <= clr_cnt;
        vram.vram_data <= CLEAR_CHAR;
      end else if (pop && in_range) begin
        vram.vram_we   <= 1'b1;
        vram.vram_addr <= head.pos[ADDR_W-1:0];
        vram.vram_data <= head.chr;
      end
    end
  end

endmodule

// File: tb/tb_vga_char_writer.sv
// Bench for vga_char_writer: directed scenarios plus random traffic,
// checked cycle by cycle against a queue-based transaction model.
module tb_vga_char_writer;
  import vga_char_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        vf    = 1'b0;
  logic        clr   = 1'b0;
  logic [15:0] pos   = '0;
  logic [15:0] chr   = '0;
  logic        busy;
  logic        overflow;
  logic        range_err;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  vga_char_writer_if bus();

  vga_char_writer dut (
    .wire_clock   (clk),
    .wire_reset   (rst_n),
    .videoflag    (vf),
    .bus_vga_pos  (pos),
    .bus_vga_char (chr),
    .clr_req      (clr),
    .vram         (bus),
    .busy         (busy),
    .overflow     (overflow),
    .range_err    (range_err),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: pending requests as a queue, screen clear as a count
  vga_req_t q[$];
  bit       m_vf, m_clr, m_clearing, m_of, m_re, e_we;
  int       m_cnt, m_drops, e_addr, e_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_vf = 0; m_clr = 0; m_clearing = 0; m_of = 0; m_re = 0;
      m_cnt = 0; m_drops = 0; e_we = 0;
    end else begin
      vga_req_t r;
      e_we = 0;
      if (m_clearing) begin
        if (bus.vram_ready) begin
          e_we = 1; e_addr = m_cnt; e_data = 0;
          m_cnt++;
          if (m_cnt == CELLS) m_clearing = 0;
        end
      end else if (clr && !m_clr) begin
        m_clearing = 1; m_cnt = 0;
      end else if (q.size() > 0 && bus.vram_ready) begin
        r = q.pop_front();
        if (r.pos < CELLS) begin
          e_we = 1; e_addr = r.pos; e_data = r.chr;
        end else begin
          m_re = 1; m_drops++;
        end
      end
      if (vf && !m_vf) begin
        if (q.size() == FIFO_DEPTH) begin
          m_of = 1; m_drops++;
        end else begin
          q.push_back('{pos: pos, chr: chr});
        end
      end
      m_vf = vf; m_clr = clr;
      #1;
      check("vram_we", bus.vram_we, e_we);
      if (e_we) begin
        check("vram_addr", bus.vram_addr, e_addr);
        check("vram_data", bus.vram_data, e_data);
      end
      check("busy", busy, m_clearing || q.size() > 0);
      check("overflow", overflow, m_of);
      check("range_err", range_err, m_re);
      check("drop_cnt", drop_cnt, (m_drops > 255) ? 255 : m_drops);
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(logic [15:0] p, logic [15:0] c, int hold);
    @(negedge clk);
    pos = p; chr = c; vf = 1'b1;
    repeat (hold) @(negedge clk);
    vf = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic wait_idle(int limit, bit toggle);
    bit done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (toggle) bus.vram_ready = ~bus.vram_ready;
      done = !m_clearing && q.size() == 0;
    end
    check("drain_timeout", done, 1);
    bus.vram_ready = 1'b1;
    tick(2);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_we"}, bus.vram_we, 0);
    check({tag, "_addr"}, bus.vram_addr, 0);
    check({tag, "_data"}, bus.vram_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_rerr"}, range_err, 0);
    check({tag, "_drops"}, drop_cnt, 0);
  endtask

  initial begin
    bus.vram_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    tick(3);
    rst_n = 1'b1;

    // single write held high for three cycles
    bus.vram_ready = 1'b1;
    send(16'h0206, 16'h0246, 3);
    tick(4);
    check("single_busy_after", busy, 0);

    // backpressure: six requests, four fit
    bus.vram_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(16'(i), 16'h0100 + 16'(i), 1);
    tick(2);
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_cnt, 2);
    bus.vram_ready = 1'b1;
    wait_idle(20, 0);

    // out of range then last legal cell
    send(16'd1200, 16'h0041, 1);
    tick(3);
    check("range_flag", range_err, 1);
    check("range_drops", drop_cnt, 3);
    send(16'd1199, 16'h1234, 1);
    tick(3);

    // clear with a request arriving mid-clear
    pulse_clr();
    tick(5);
    send(16'd5, 16'h0733, 1);
    wait_idle(1400, 0);

    // clear with ready toggling every cycle
    pulse_clr();
    wait_idle(3000, 1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.vram_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        pulse_clr();
      end else if ($urandom_range(0, 7) == 0) begin
        send(16'($urandom_range(1200, 65535)), 16'($urandom), 1);
      end else begin
        send(16'($urandom_range(0, 1199)), 16'($urandom),
             $urandom_range(1, 3));
      end
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 4));
    end
    bus.vram_ready = 1'b1;
    wait_idle(3000, 0);

    // asynchronous reset in the middle of a clear
    pulse_clr();
    begin
      bit hit = 0;
      for (int i = 0; i < 2000 && !hit; i++) begin
        @(negedge clk);
        hit = (m_cnt == 300);
      end
      check("clr_reach_300", hit, 1);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk) rst_n = 1'b1;
    tick(20);
    send(16'd7, 16'h0e07, 1);
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_char_writer.md
Name: vga_char_writer

Overview:
- Downstream consumer of the AP9 core's outchar/debug video port: videoflag, bus_vga_pos, bus_vga_char.
- Captures each write request on the rising edge of videoflag and queues it in a small FIFO.
- Drains queued requests into the character video RAM one write per cycle, only while the VGA side grants access.
- Also provides a full-screen clear sequencer, so the core never stalls on the video RAM.

Parameters:
- COLS, 40, characters per row
- ROWS, 30, character rows
- CELLS, COLS*ROWS (1200), number of character cells
- ADDR_W, 11, video RAM address width (must satisfy 2**ADDR_W >= CELLS)
- FIFO_DEPTH, 4, request queue entries (power of two)
- CLEAR_CHAR, 16'h0000, word written to every cell during clear

Ports:
- wire_clock  in  1  system clock; all logic on posedge
- wire_reset  in  1  asynchronous, active-low reset
- videoflag  in  1  request level from core; a rising edge means one request
- bus_vga_pos  in  16  cell index for the request
- bus_vga_char  in  16  character word: [7:0] code, [11:8] colour, [15:12] passed through
- clr_req  in  1  clear-screen request; a rising edge means one request
- vram_ready  in  1  VGA side grants a video RAM write this cycle
- vram_we  out  1  video RAM write strobe, one cycle per write
- vram_addr  out  ADDR_W  video RAM write address
- vram_data  out  16  video RAM write data
- busy  out  1  high while clearing or while the FIFO is non-empty
- overflow  out  1  sticky: a request was dropped because the FIFO was full
- range_err  out  1  sticky: a request had pos >= CELLS
- drop_cnt  out  8  count of dropped plus out-of-range requests; saturates at 255

Behaviour:
- Reset (wire_reset=0, async):
  - vram_we=0, vram_addr=0, vram_data=0, busy=0, overflow=0, range_err=0, drop_cnt=0.
  - FIFO emptied, state=IDLE, edge registers=0.
  - Reset mid-clear or mid-drain abandons the operation; no resume.
- Edge detect:
  - flag_q <= videoflag every cycle; req_edge = videoflag & ~flag_q.
  - clr_edge is formed the same way from clr_req.
  - A videoflag held high for many cycles produces exactly one request.
- Push:
  - On req_edge, push {bus_vga_pos, bus_vga_char} sampled in that same cycle.
  - If the FIFO is full and no pop happens that cycle: discard, set overflow, increment drop_cnt.
  - Push and pop in the same cycle while full: both succeed.
- States:
  - IDLE: each cycle with FIFO non-empty and vram_ready=1, pop the head entry.
    - pos < CELLS: vram_we<=1, vram_addr<=pos[ADDR_W-1:0], vram_data<=char.
    - pos >= CELLS: no write; set range_err, increment drop_cnt.
    - Otherwise vram_we<=0.
  - IDLE -> CLEAR on clr_edge. This takes priority over the pop in that cycle.
  - CLEAR: clr_cnt starts at 0. Each cycle with vram_ready=1: vram_we<=1, vram_addr<=clr_cnt, vram_data<=CLEAR_CHAR, clr_cnt++.
    - After the write of CELLS-1, return to IDLE.
    - vram_ready=0 holds clr_cnt and drives vram_we<=0.
    - FIFO pushes continue during CLEAR; entries drain after the clear completes, so requests issued after a clear land on the cleared screen.
    - clr_edge while in CLEAR is ignored.
- Latency: a req_edge at posedge N with an empty FIFO and vram_ready=1 gives vram_we=1 in cycle N+1. Maximum throughput is one write per cycle.
- busy = (state==CLEAR) | fifo_not_empty, registered from next-state.
- All outputs are registered. vram_addr and vram_data hold their last value when vram_we=0.

Decomposition:
- Package vga_char_pkg holds:
  - constants COLS, ROWS, CELLS, CLEAR_CHAR;
  - typedef vga_req_t = struct {pos[15:0], chr[15:0]};
  - enum wr_state_t {IDLE, CLEAR}.
- One sub-module: sync_fifo (parameters WIDTH=32, DEPTH=FIFO_DEPTH; ports push, pop, din, dout, full, empty, same async active-low reset). The top level owns edge detection, the FSM and the counters.

Test Plan:
- Single write: vram_ready=1, videoflag 0->1 held 3 cycles, pos=16'h0206, char=16'h0246 -> exactly one vram_we pulse, one cycle after the edge, with addr=11'h206 and data=16'h0246. busy is back to 0 afterwards.
- Backpressure and overflow: vram_ready=0, send 6 requests (pos 0..5) -> FIFO holds pos 0..3; overflow=1, drop_cnt=2. Raise vram_ready -> 4 consecutive writes to addr 0,1,2,3 in order.
- Out of range: pos=1200, char=16'h0041 -> no vram_we; range_err=1, drop_cnt increments by 1. A following pos=1199 request writes addr 1199.
- Clear with interleaved request: pulse clr_req, then pos=5 char=16'h0733 during the clear -> 1200 writes of 16'h0000 to addr 0..1199, then one write 16'h0733 at addr 5. busy stays high throughout.
- Clear with ready gaps: toggle vram_ready 1,0,1,0 during the clear -> exactly 1200 writes, no address skipped or repeated.
- Async reset mid-clear at clr_cnt=300 -> all outputs 0 immediately, without waiting for a clock edge. No further writes until a new request arrives.
